dm_dump_ctrl: RTL and testbench

Post-run readout engine for the data memory. Once the core raises done, it takes the dm1 address port and reads a programmed address window one byte at a time. Each byte goes out on a valid/ready stream with its address, so benches and host logic can check results without hierarchical peeks. It sits beside top_level's data memory, behind the dm address mux.

---
 rtl/dump_pkg.sv | 18 +
 rtl/dm_dump_ctrl.sv | 176 +++++++++++++++++
 tb/tb_dm_dump_ctrl.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/dump_pkg.sv
// Shared types for the data-memory dump controller: FSM state encoding,
// default geometry and the address type.
package dump_pkg;

    localparam int AW_DEF = 8;
    localparam int DW_DEF = 8;

    typedef logic [AW_DEF-1:0] addr_t;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        SEND = 3'd2,
        FIN  = 3'd3,
        CSUM = 3'd4
    } dump_state_t;

endpackage

// File: rtl/dm_dump_ctrl.sv
// Post-run data-memory readout: streams a wrapping address window one byte per beat.
// Optional trailing checksum beat when DUMP_CHECKSUM_EN is defined.
module dm_dump_ctrl
    import dump_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cpu_done,
    input  logic [AW-1:0] first_addr,
    input  logic [AW-1:0] last_addr,
    output logic          dm_sel,
    output logic [AW-1:0] dm_addr,
    input  logic [DW-1:0] dm_rd_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic [AW-1:0] out_addr,
    output logic          out_last,
    output logic          busy,
    output logic          dump_done
);

    dump_state_t   r_state, w_state;
    logic [AW-1:0] r_ptr, w_ptr;
    logic [AW-1:0] r_last, w_last;
    logic          r_dm_sel, w_dm_sel;
    logic          r_busy, w_busy;
    logic          r_done, w_done;
    logic          r_valid, w_valid;
    logic [DW-1:0] r_data, w_data;
    logic [AW-1:0] r_addr, w_addr;
    logic          r_olast, w_olast;
    logic          w_accept;
`ifdef DUMP_CHECKSUM_EN
    logic [DW-1:0] r_sum, w_sum;
`endif

    assign w_accept = r_valid & out_ready;

    // Next-state and next-datapath logic for the dump sequencer
    always_comb begin
        w_state  = r_state;
        w_ptr    = r_ptr;
        w_last   = r_last;
        w_dm_sel = r_dm_sel;
        w_busy   = r_busy;
        w_done   = r_done;
        w_valid  = r_valid;
        w_data   = r_data;
        w_addr   = r_addr;
        w_olast  = r_olast;
`ifdef DUMP_CHECKSUM_EN
        w_sum    = r_sum;
`endif
        case (r_state)
            IDLE: begin
                if (cpu_done) begin
                    w_ptr    = first_addr;
                    w_last   = last_addr;
                    w_dm_sel = 1'b1;
                    w_busy   = 1'b1;
`ifdef DUMP_CHECKSUM_EN
                    w_sum    = {DW{1'b0}};
`endif
                    w_state  = LOAD;
                end else begin
                    w_state  = IDLE;
                end
            end
            LOAD: begin
                w_data  = dm_rd_data;
                w_addr  = r_ptr;
`ifdef DUMP_CHECKSUM_EN
                w_olast = 1'b0;
`else
                w_olast = (r_ptr == r_last);
`endif
                w_valid = 1'b1;
                w_state = SEND;
            end
            SEND: begin
                if (w_accept) begin
                    w_valid = 1'b0;
`ifdef DUMP_CHECKSUM_EN
                    w_sum   = r_sum + r_data;
`endif
                    if (r_ptr != r_last) begin
                        w_ptr   = r_ptr + {{(AW-1){1'b0}}, 1'b1};
                        w_state = LOAD;
                    end else begin
`ifdef DUMP_CHECKSUM_EN
                        // Checksum beat reuses the output registers, tagged with the last address
                        w_valid = 1'b1;
                        w_data  = r_sum + r_data;
                        w_addr  = r_last;
                        w_olast = 1'b1;
                        w_state = CSUM;
`else
                        w_dm_sel = 1'b0;
                        w_busy   = 1'b0;
                        w_done   = 1'b1;
                        w_state  = FIN;
`endif
                    end
                end else begin
                    w_state = SEND;
                end
            end
`ifdef DUMP_CHECKSUM_EN
            CSUM: begin
                if (w_accept) begin
                    w_valid  = 1'b0;
                    w_dm_sel = 1'b0;
                    w_busy   = 1'b0;
                    w_done   = 1'b1;
                    w_state  = FIN;
                end else begin
                    w_state  = CSUM;
                end
            end
`endif
            FIN: begin
                w_state = FIN;
            end
            default: begin
                w_state = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any dump in progress
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= IDLE;
            r_ptr    <= {AW{1'b0}};
            r_last   <= {AW{1'b0}};
            r_dm_sel <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_valid  <= 1'b0;
            r_data   <= {DW{1'b0}};
            r_addr   <= {AW{1'b0}};
            r_olast  <= 1'b0;
`ifdef DUMP_CHECKSUM_EN
            r_sum    <= {DW{1'b0}};
`endif
        end else begin
            r_state  <= w_state;
            r_ptr    <= w_ptr;
            r_last   <= w_last;
            r_dm_sel <= w_dm_sel;
            r_busy   <= w_busy;
            r_done   <= w_done;
            r_valid  <= w_valid;
            r_data   <= w_data;
            r_addr   <= w_addr;
            r_olast  <= w_olast;
`ifdef DUMP_CHECKSUM_EN
            r_sum    <= w_sum;
`endif
        end
    end

    assign dm_sel    = r_dm_sel;
    assign dm_addr   = r_dm_sel ? r_ptr : {AW{1'b0}};
    assign out_valid = r_valid;
    assign out_data  = r_data;
    assign out_addr  = r_addr;
    assign out_last  = r_olast;
    assign busy      = r_busy;
    assign dump_done = r_done;

endmodule

// File: tb/tb_dm_dump_ctrl.sv
// Scoreboard bench for dm_dump_ctrl: directed windows, backpressure, wrap,
// retrigger and mid-dump reset; expects a checksum beat when DUMP_CHECKSUM_EN is defined.
module tb_dm_dump_ctrl;

    localparam int AW = 8;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          cpu_done;
    logic [AW-1:0] first_addr;
    logic [AW-1:0] last_addr;
    logic          dm_sel;
    logic [AW-1:0] dm_addr;
    logic [DW-1:0] dm_rd_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [AW-1:0] out_addr;
    logic          out_last;
    logic          busy;
    logic          dump_done;

    logic [DW-1:0] mem [256];

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic          l;
    } beat_t;

    beat_t exp_q[$];
    int    n_tests      = 0;
    int    n_fail       = 0;
    int    acc_count    = 0;
    int    stall_cycles = 0;
    logic  prev_v       = 1'b0;
    logic  prev_r       = 1'b0;
    beat_t prev_b;

    dm_dump_ctrl #(.AW(AW), .DW(DW)) dut (
        .clk        (clk),
        .reset      (reset),
        .cpu_done   (cpu_done),
        .first_addr (first_addr),
        .last_addr  (last_addr),
        .dm_sel     (dm_sel),
        .dm_addr    (dm_addr),
        .dm_rd_data (dm_rd_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_addr   (out_addr),
        .out_last   (out_last),
        .busy       (busy),
        .dump_done  (dump_done)
    );

    assign dm_rd_data = mem[dm_addr];

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Monitor: pops the scoreboard on every handshake and checks stall stability
    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_v = 1'b0;
                prev_r = 1'b0;
            end else begin
                if (out_valid && prev_v && !prev_r)
                    check("stall_stable", {out_addr, out_data, out_last}, prev_b);
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_beat", {out_addr, out_data, out_last}, 64'hFFFF_FFFF_FFFF_FFFF);
                    end else begin
                        check("beat", {out_addr, out_data, out_last}, exp_q.pop_front());
                    end
                    acc_count++;
                end
                prev_v = out_valid;
                prev_r = out_ready;
                prev_b = {out_addr, out_data, out_last};
            end
        end
    end

    // Ready driver: holds out_ready low for stall_cycles at the start of each beat
    initial begin
        int cnt;
        cnt = 0;
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (!out_valid) begin
                out_ready = (stall_cycles == 0);
                cnt = 0;
            end else if (cnt < stall_cycles) begin
                out_ready = 1'b0;
                cnt++;
            end else begin
                out_ready = 1'b1;
            end
        end
    end

    task automatic push_beat(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic last);
`ifdef DUMP_CHECKSUM_EN
        exp_q.push_back({a, d, 1'b0});
`else
        exp_q.push_back({a, d, last});
`endif
    endtask

    task automatic push_csum(input logic [AW-1:0] a, input logic [DW-1:0] s);
`ifdef DUMP_CHECKSUM_EN
        exp_q.push_back({a, s, 1'b1});
`endif
    endtask

    task automatic push_basic();
        push_beat(8'd0, 8'h01, 1'b0);
        push_beat(8'd1, 8'h02, 1'b0);
        push_beat(8'd2, 8'h00, 1'b0);
        push_beat(8'd3, 8'hC3, 1'b0);
        push_beat(8'd4, 8'h55, 1'b1);
        push_csum(8'd4, 8'h1B);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cpu_done = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        exp_q.delete();
        acc_count = 0;
    endtask

    task automatic run_dump(input string name, input int nbeats, input bit timing);
        int cyc;
        int first_v;
        int exp_done;
        cyc = 0;
        first_v = -1;
        cpu_done = 1'b1;
        while (!dump_done && cyc < 2000) begin
            @(posedge clk);
            #1;
            cyc++;
            if (cyc == 1) begin
                cpu_done = 1'b0;
                first_addr = 8'h77;
                last_addr = 8'h78;
            end
            if (out_valid && first_v < 0) first_v = cyc;
        end
        if (!dump_done) begin
            check({name, "_timeout"}, 64'd0, 64'd1);
        end else if (timing) begin
`ifdef DUMP_CHECKSUM_EN
            exp_done = 2 * nbeats + 2;
`else
            exp_done = 2 * nbeats + 1;
`endif
            check({name, "_latency"}, 64'(first_v), 64'd2);
            check({name, "_done_cycle"}, 64'(cyc), 64'(exp_done));
        end
        repeat (2) @(posedge clk);
        #1;
        check({name, "_q_empty"}, 64'(exp_q.size()), 64'd0);
        check({name, "_end_flags"}, {dump_done, dm_sel, busy, out_valid, dm_addr}, {1'b1, 1'b0, 1'b0, 1'b0, 8'h00});
    endtask

    initial begin
        int guard;
        for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h5A;
        mem[0] = 8'h01; mem[1] = 8'h02; mem[2] = 8'h00; mem[3] = 8'hC3; mem[4] = 8'h55;
        mem[254] = 8'hAA; mem[255] = 8'hBB;
        reset = 1'b1;
        cpu_done = 1'b0;
        first_addr = 8'h00;
        last_addr = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", {dm_sel, dm_addr, out_valid, out_data, out_addr, out_last, busy, dump_done}, 64'd0);
        reset = 1'b0;

        // Basic window at full throughput
        do_reset();
        stall_cycles = 0;
        first_addr = 8'd0; last_addr = 8'd4;
        push_basic();
        run_dump("basic", 5, 1'b1);

        // Same window with 3-cycle stalls on every beat
        do_reset();
        stall_cycles = 3;
        first_addr = 8'd0; last_addr = 8'd4;
        push_basic();
        run_dump("backpressure", 5, 1'b0);
        stall_cycles = 0;

        // Wrap from 254 through 0
        do_reset();
        first_addr = 8'd254; last_addr = 8'd0;
        push_beat(8'd254, 8'hAA, 1'b0);
        push_beat(8'd255, 8'hBB, 1'b0);
        push_beat(8'd0, 8'h01, 1'b1);
        push_csum(8'd0, 8'h66);
        run_dump("wrap", 3, 1'b1);

        // Single beat, then a retrigger attempt that must be ignored
        do_reset();
        first_addr = 8'd3; last_addr = 8'd3;
        push_beat(8'd3, 8'hC3, 1'b1);
        push_csum(8'd3, 8'hC3);
        run_dump("single", 1, 1'b1);
        first_addr = 8'd0; last_addr = 8'd4;
        cpu_done = 1'b0;
        repeat (2) @(posedge clk);
        cpu_done = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        cpu_done = 1'b0;
        check("retrigger_flags", {dump_done, busy, dm_sel, out_valid}, {1'b1, 1'b0, 1'b0, 1'b0});

        // Reset while the third beat is being fetched
        do_reset();
        first_addr = 8'd0; last_addr = 8'd4;
        push_basic();
        cpu_done = 1'b1;
        guard = 0;
        while (acc_count < 2 && guard < 200) begin
            @(posedge clk);
            #1;
            guard++;
        end
        check("midreset_reach", 64'(acc_count), 64'd2);
        cpu_done = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("midreset_outputs", {dm_sel, dm_addr, out_valid, out_data, out_addr, out_last, busy, dump_done}, 64'd0);
        reset = 1'b0;
        exp_q.delete();
        push_basic();
        run_dump("after_reset", 5, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
